// File: rtl/zz_rle_enc.sv
// Run-length encoder for zigzag-ordered coefficient blocks.
// Emits one DC token per block, (run, level) per nonzero AC, and EOB when the block ends in zeros.
module zz_rle_enc #(
    parameter int DW      = 10,
    parameter int BLK_LEN = 64,
    parameter int DC_DIFF = 1,
    localparam int CW     = $clog2(BLK_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vld_in,
    input  logic [DW-1:0] din,
    output logic          vld_out,
    output logic          dc_out,
    output logic [CW-1:0] run,
    output logic [DW:0]   level,
    output logic          eob,
    output logic          last
);

    typedef enum logic {S_DC, S_AC} state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(BLK_LEN - 1);

    state_t        state, state_nx;
    logic [CW-1:0] idx, idx_nx;
    logic [CW-1:0] zrun, zrun_nx;
    logic [DW-1:0] prev_dc, prev_dc_nx;

    logic          vld_nx, dc_nx, eob_nx, last_nx;
    logic [CW-1:0] run_nx;
    logic [DW:0]   level_nx;
    logic [DW:0]   din_x, prev_x;

    assign din_x  = {din[DW-1], din};
    assign prev_x = {prev_dc[DW-1], prev_dc};

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        zrun_nx    = zrun;
        prev_dc_nx = prev_dc;
        vld_nx     = 1'b0;
        dc_nx      = 1'b0;
        eob_nx     = 1'b0;
        last_nx    = 1'b0;
        run_nx     = '0;
        level_nx   = '0;
        if (vld_in) begin
            unique case (state)
                S_DC: begin
                    vld_nx     = 1'b1;
                    dc_nx      = 1'b1;
                    // DC_DIFF=1: level is DPCM against the previous block's DC
                    level_nx   = (DC_DIFF != 0) ? din_x - prev_x : din_x;
                    prev_dc_nx = din;
                    idx_nx     = CW'(1);
                    zrun_nx    = '0;
                    state_nx   = S_AC;
                end
                S_AC: begin
                    if (idx == LAST_IDX) begin
                        vld_nx  = 1'b1;
                        last_nx = 1'b1;
                        if (din != '0) begin
                            run_nx   = zrun;
                            level_nx = din_x;
                        end else begin
                            eob_nx = 1'b1;
                        end
                        idx_nx   = '0;
                        zrun_nx  = '0;
                        state_nx = S_DC;
                    end else begin
                        if (din != '0) begin
                            vld_nx   = 1'b1;
                            run_nx   = zrun;
                            level_nx = din_x;
                            zrun_nx  = '0;
                        end else begin
                            zrun_nx = zrun + CW'(1);
                        end
                        idx_nx = idx + CW'(1);
                    end
                end
                default: state_nx = S_DC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_DC;
            idx     <= '0;
            zrun    <= '0;
            prev_dc <= '0;
            vld_out <= 1'b0;
            dc_out  <= 1'b0;
            run     <= '0;
            level   <= '0;
            eob     <= 1'b0;
            last    <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            zrun    <= zrun_nx;
            prev_dc <= prev_dc_nx;
            vld_out <= vld_nx;
            dc_out  <= dc_nx;
            run     <= run_nx;
            level   <= level_nx;
            eob     <= eob_nx;
            last    <= last_nx;
        end
    end

endmodule

// File: tb/tb_zz_rle_enc.sv
// Scoreboard bench for zz_rle_enc: DPCM and plain-DC builds driven in parallel
// against a block-level token model.
module tb_zz_rle_enc;

    localparam int HALF = 5;

    typedef struct {
        logic dc;
        int   run;
        int   level;
        logic eob;
        logic last;
        int   idx;
    } tok_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld_in;
    logic [9:0]  din;
    logic        vo[2];
    logic        dco[2];
    logic [5:0]  rn[2];
    logic [10:0] lv[2];
    logic        eo[2];
    logic        la[2];

    tok_t q[2][$];
    time  beat_t[64];
    int   blk[64];
    int   model_prev;
    int   npass;
    int   ntot;

    always #HALF clk = ~clk;

    zz_rle_enc #(.DW(10), .BLK_LEN(64), .DC_DIFF(0)) u_dut0 (
        .clk(clk), .rst(rst), .vld_in(vld_in), .din(din),
        .vld_out(vo[0]), .dc_out(dco[0]), .run(rn[0]), .level(lv[0]),
        .eob(eo[0]), .last(la[0])
    );

    zz_rle_enc #(.DW(10), .BLK_LEN(64), .DC_DIFF(1)) u_dut1 (
        .clk(clk), .rst(rst), .vld_in(vld_in), .din(din),
        .vld_out(vo[1]), .dc_out(dco[1]), .run(rn[1]), .level(lv[1]),
        .eob(eo[1]), .last(la[1])
    );

    function automatic tok_t mk(logic dc, int r, int l, logic e, logic lst, int i);
        tok_t t;
        t.dc = dc; t.run = r; t.level = l; t.eob = e; t.last = lst; t.idx = i;
        return t;
    endfunction

    // Expected tokens for the first n coefficients of blk[]
    task automatic push_block(input int n);
        int last_nz;
        q[0].push_back(mk(1'b1, 0, blk[0], 1'b0, 1'b0, 0));
        q[1].push_back(mk(1'b1, 0, blk[0] - model_prev, 1'b0, 1'b0, 0));
        model_prev = blk[0];
        last_nz = 0;
        for (int i = 1; i < n; i++) begin
            tok_t t;
            if (i == 63) begin
                if (blk[i] != 0) t = mk(1'b0, i - last_nz - 1, blk[i], 1'b0, 1'b1, i);
                else             t = mk(1'b0, 0, 0, 1'b1, 1'b1, i);
                q[0].push_back(t);
                q[1].push_back(t);
            end else if (blk[i] != 0) begin
                t = mk(1'b0, i - last_nz - 1, blk[i], 1'b0, 1'b0, i);
                q[0].push_back(t);
                q[1].push_back(t);
                last_nz = i;
            end
        end
    endtask

    task automatic send_beat(input int d, input int i, input int gap);
        for (int g = 0; g < gap; g++) begin
            vld_in = 1'b0;
            din = 10'($urandom);
            @(posedge clk); #1;
        end
        vld_in = 1'b1;
        din = 10'(d);
        @(posedge clk);
        beat_t[i] = $time;
        #1;
        vld_in = 1'b0;
        din = '0;
    endtask

    // mode 0: contiguous, 1: alternate idle cycles, 2: random gaps
    task automatic send_block(input int n, input int mode);
        push_block(n);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = 0;
            if (mode == 1 && i > 0) gap = 1;
            if (mode == 2 && $urandom_range(0, 3) == 0) gap = $urandom_range(1, 3);
            send_beat(blk[i], i, gap);
        end
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = 0;
    endtask

    task automatic block_a();
        clear_blk();
        blk[0] = 100; blk[1] = 5; blk[5] = -3;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (vo[k]) begin
                ntot++;
                if (q[k].size() == 0) begin
                    $display("FAIL tok%0d: unexpected token run=%0d level=%0d eob=%0d, none required",
                             k, rn[k], $signed(lv[k]), eo[k]);
                end else begin
                    tok_t e;
                    e = q[k].pop_front();
                    if (dco[k] !== e.dc || int'(rn[k]) != e.run || int'($signed(lv[k])) != e.level
                        || eo[k] !== e.eob || la[k] !== e.last || $time != beat_t[e.idx] + HALF)
                        $display("FAIL tok%0d idx%0d: got dc=%0d run=%0d lvl=%0d eob=%0d last=%0d t=%0t, need dc=%0d run=%0d lvl=%0d eob=%0d last=%0d t=%0t",
                                 k, e.idx, dco[k], rn[k], $signed(lv[k]), eo[k], la[k], $time,
                                 e.dc, e.run, e.level, e.eob, e.last, beat_t[e.idx] + HALF);
                    else
                        npass++;
                end
            end else begin
                ntot++;
                if (dco[k] !== 1'b0 || rn[k] !== '0 || lv[k] !== '0 || eo[k] !== 1'b0 || la[k] !== 1'b0)
                    $display("FAIL idle%0d: got dc=%0d run=%0d lvl=%0d eob=%0d last=%0d, need all 0",
                             k, dco[k], rn[k], lv[k], eo[k], la[k]);
                else
                    npass++;
            end
        end
    end

    initial begin
        npass = 0;
        ntot = 0;
        model_prev = 0;
        rst = 1'b1;
        vld_in = 1'b1;
        din = 10'd55;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        vld_in = 1'b0;
        din = '0;

        block_a();
        send_block(64, 0);
        clear_blk();
        blk[0] = 90; blk[63] = 7;
        send_block(64, 0);
        block_a();
        send_block(64, 1);

        for (int i = 0; i < 64; i++) blk[i] = (i % 7 == 3) ? i - 20 : 0;
        blk[0] = 33;
        send_block(30, 2);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_prev = 0;

        clear_blk();
        blk[0] = -512; blk[62] = 511;
        send_block(64, 0);
        clear_blk();
        blk[0] = 511; blk[1] = -512;
        send_block(64, 2);
        clear_blk();
        send_block(64, 0);

        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < 64; i++)
                blk[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) - 512 : 0;
            blk[0] = int'($urandom_range(0, 1023)) - 512;
            if (b % 3 == 0) blk[63] = 0;
            send_block(64, b % 3);
        end

        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            ntot++;
            if (q[k].size() != 0)
                $display("FAIL drain%0d: %0d tokens outstanding, need 0", k, q[k].size());
            else
                npass++;
        end
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
